pwr_down_seq: RTL and testbench

Reverse-order power-down sequencer for the standby-clocked PwrSequence domain. It gates the rail enables produced by the power-up sequencing blocks through a per-rail permission mask. On a shutdown request or fault, it withdraws permission one rail at a time, from highest index to lowest. Before moving to the next rail it waits for the current rail's power-good to drop, or for a timeout to expire. It sits beside MstrSeq under PwrSequence, and each mask bit is ANDed with the matching `*_EN` output.

---
 rtl/pwr_down_pkg.sv | 19 +
 rtl/pwr_down_seq_timer.sv | 33 +++
 rtl/pwr_down_seq.sv | 132 +++++++++++++
 tb/tb_pwr_down_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_down_pkg.sv
// Shared types and defaults for the reverse-order power-down sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package pwr_down_pkg;

   // Encoding is visible on the debug pins, so values are pinned.
   typedef enum logic [1:0] {
      OFF   = 2'd0,
      ON    = 2'd1,
      DRAIN = 2'd2
   } pd_state_e;

   localparam int PD_TMR_W          = 16;
   localparam int PD_NUM_RAILS_DEF  = 6;
   localparam int PD_MIN_DWELL_DEF  = 2;
   localparam int PD_TIMEOUT_DEF    = 330;
   localparam int PD_OFF_HOLD_DEF   = 33;

endpackage

// File: rtl/pwr_down_seq_timer.sv
// Saturating up-counter with synchronous clear, used for step dwell/timeout and OFF hold.
// Latency: count reflects clr/inc one cycle after the edge that samples them.
// Backpressure: none; counter simply stops at MAX.
//
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (count enable), count (current value, saturates at MAX).
module pd_step_timer
   import pwr_down_pkg::*;
#(
   parameter int W   = PD_TMR_W,
   parameter int MAX = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_C = MAX[W-1:0];
   localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count < MAX_C)) begin
         count <= count + ONE_C;
      end
   end

endmodule

// File: rtl/pwr_down_seq.sv
// Reverse-order power-down sequencer: withdraws per-rail enable permission from the highest rail down.
// Latency: trigger edge clears the top rail's permission; each step takes MIN_DWELL+1 cycles (TIMEOUT+1 if PG sticks).
// Backpressure: a step stalls until the rail's power-good drops or the timeout forces the advance.
//
// Ports: CLK_33K_SUSCLK_PLD_R2 (standby clock), RST_RSMRST_N (async active-low reset),
//        pwr_on_req / fault_in (level requests), rail_pg (per-rail power-good),
//        rail_en_mask (per-rail permission), seq_busy, down_done (pulse),
//        timeout_err (sticky), timeout_rail (first rail that timed out), state_dbg.
module pwr_down_seq
   import pwr_down_pkg::*;
#(
   parameter int NUM_RAILS = PD_NUM_RAILS_DEF,
   parameter int MIN_DWELL = PD_MIN_DWELL_DEF,
   parameter int TIMEOUT   = PD_TIMEOUT_DEF,
   parameter int OFF_HOLD  = PD_OFF_HOLD_DEF
) (
   input  logic                         CLK_33K_SUSCLK_PLD_R2,
   input  logic                         RST_RSMRST_N,
   input  logic                         pwr_on_req,
   input  logic                         fault_in,
   input  logic [NUM_RAILS-1:0]         rail_pg,
   output logic [NUM_RAILS-1:0]         rail_en_mask,
   output logic                         seq_busy,
   output logic                         down_done,
   output logic                         timeout_err,
   output logic [$clog2(NUM_RAILS)-1:0] timeout_rail,
   output logic [1:0]                   state_dbg
);

   localparam int                  IDX_W    = $clog2(NUM_RAILS);
   localparam int                  LAST     = NUM_RAILS - 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = LAST[IDX_W-1:0];
   localparam logic [IDX_W-1:0]    IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [PD_TMR_W-1:0] DWELL_C  = MIN_DWELL[PD_TMR_W-1:0];
   localparam logic [PD_TMR_W-1:0] TMO_C    = TIMEOUT[PD_TMR_W-1:0];
   localparam logic [PD_TMR_W-1:0] HOLD_C   = OFF_HOLD[PD_TMR_W-1:0];

   pd_state_e            state;
   logic [IDX_W-1:0]     idx;
   logic [PD_TMR_W-1:0]  step_tmr;
   logic [PD_TMR_W-1:0]  hold_cnt;
   logic                 step_normal;
   logic                 step_tmo;
   logic                 step_adv;

   // Step timer runs only in DRAIN and restarts at each rail; it saturates at
   // TIMEOUT so the forced-advance compare stays an equality.
   pd_step_timer #(.W(PD_TMR_W), .MAX(TIMEOUT)) u_step_tmr (
      .clk   (CLK_33K_SUSCLK_PLD_R2),
      .rst_n (RST_RSMRST_N),
      .clr   ((state != DRAIN) || step_adv),
      .inc   (1'b1),
      .count (step_tmr)
   );

   // Hold counter only accumulates while OFF, so every OFF entry starts from 0.
   pd_step_timer #(.W(PD_TMR_W), .MAX(OFF_HOLD)) u_hold_tmr (
      .clk   (CLK_33K_SUSCLK_PLD_R2),
      .rst_n (RST_RSMRST_N),
      .clr   (state != OFF),
      .inc   (1'b1),
      .count (hold_cnt)
   );

   // A rail whose PG drops exactly as the timer reaches TIMEOUT is treated as
   // a normal step, not an error.
   assign step_normal = (step_tmr >= DWELL_C) && !rail_pg[idx];
   assign step_tmo    = (step_tmr == TMO_C);
   assign step_adv    = step_normal || step_tmo;

   always_ff @(posedge CLK_33K_SUSCLK_PLD_R2 or negedge RST_RSMRST_N) begin
      if (!RST_RSMRST_N) begin
         state        <= OFF;
         idx          <= '0;
         rail_en_mask <= '0;
         seq_busy     <= 1'b0;
         down_done    <= 1'b0;
         timeout_err  <= 1'b0;
         timeout_rail <= '0;
      end else begin
         down_done <= 1'b0;
         case (state)
            OFF: begin
               rail_en_mask <= '0;
               seq_busy     <= 1'b0;
               if (pwr_on_req && !fault_in && (hold_cnt == HOLD_C)) begin
                  state        <= ON;
                  rail_en_mask <= '1;
                  timeout_err  <= 1'b0;
                  timeout_rail <= '0;
               end
            end
            ON: begin
               rail_en_mask <= '1;
               if (!pwr_on_req || fault_in) begin
                  state              <= DRAIN;
                  idx                <= LAST_IDX;
                  rail_en_mask[LAST] <= 1'b0;
                  seq_busy           <= 1'b1;
               end
            end
            DRAIN: begin
               // Requests are ignored here: once started, the drain always finishes.
               if (step_adv) begin
                  if (!step_normal) begin
                     timeout_err <= 1'b1;
                     if (!timeout_err) begin
                        timeout_rail <= idx;
                     end
                  end
                  if (idx == '0) begin
                     state     <= OFF;
                     seq_busy  <= 1'b0;
                     down_done <= 1'b1;
                  end else begin
                     idx                         <= idx - IDX_ONE;
                     rail_en_mask[idx - IDX_ONE] <= 1'b0;
                  end
               end
            end
            default: begin
               state        <= OFF;
               rail_en_mask <= '0;
               seq_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_pwr_down_seq.sv
// Directed bench for pwr_down_seq with NUM_RAILS=4, MIN_DWELL=2, TIMEOUT=10, OFF_HOLD=5.
// Latency: vectors are applied one per clock and checked 1 time unit after the edge.
// Backpressure: n/a.
module tb_pwr_down_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pwr_on_req;
   logic       fault_in;
   logic [3:0] rail_pg;
   logic [3:0] rail_en_mask;
   logic       seq_busy;
   logic       down_done;
   logic       timeout_err;
   logic [1:0] timeout_rail;
   logic [1:0] state_dbg;

   int n_vec = 0;
   int n_bad = 0;

   pwr_down_seq #(
      .NUM_RAILS (4),
      .MIN_DWELL (2),
      .TIMEOUT   (10),
      .OFF_HOLD  (5)
   ) dut (
      .CLK_33K_SUSCLK_PLD_R2 (clk),
      .RST_RSMRST_N          (rst_n),
      .pwr_on_req            (pwr_on_req),
      .fault_in              (fault_in),
      .rail_pg               (rail_pg),
      .rail_en_mask          (rail_en_mask),
      .seq_busy              (seq_busy),
      .down_done             (down_done),
      .timeout_err           (timeout_err),
      .timeout_rail          (timeout_rail),
      .state_dbg             (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pon;
      logic       flt;
      logic [3:0] pg;
      logic [3:0] mask;
      logic       busy;
      logic       done;
      logic       terr;
      logic [1:0] trail;
      logic [1:0] st;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   int step_len [4];
   int steps_seen;
   bit mono_ok;

   function automatic vec_t v(input logic pon, input logic flt, input logic [3:0] pg,
                              input logic [3:0] mask, input logic busy, input logic done,
                              input logic terr, input logic [1:0] trail, input logic [1:0] st);
      vec_t r;
      r.pon = pon; r.flt = flt; r.pg = pg; r.mask = mask; r.busy = busy;
      r.done = done; r.terr = terr; r.trail = trail; r.st = st;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] outs();
      return {rail_en_mask, seq_busy, down_done, timeout_err, timeout_rail, state_dbg};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requests power-on and counts edges until ON is reached (bounded).
   task automatic wait_on(output int edges);
      pwr_on_req = 1'b1;
      fault_in   = 1'b0;
      rail_pg    = 4'h0;
      edges      = 0;
      while (state_dbg != 2'd1 && edges < 50) begin
         tick();
         edges++;
      end
   endtask

   // Triggers a drain from ON; PG follows the mask one cycle later except for
   // 'stuck' bits. Records each step's length in edges (trigger edge = start).
   task automatic run_drain(input logic [3:0] stuck, input logic trig_pon, input logic trig_flt,
                            input logic mid_pon, input logic mid_flt);
      logic [3:0] prev;
      int cnt;
      int n;
      pwr_on_req = trig_pon;
      fault_in   = trig_flt;
      rail_pg    = 4'hF;
      tick();
      chk("trig_state", state_dbg, 2'd2);
      chk("trig_mask", rail_en_mask, 4'h7);
      pwr_on_req = mid_pon;
      fault_in   = mid_flt;
      prev       = rail_en_mask;
      cnt        = 0;
      n          = 0;
      steps_seen = 0;
      mono_ok    = 1'b1;
      for (int i = 0; i < 4; i++) step_len[i] = 0;
      while (steps_seen < 4 && n < 200) begin
         rail_pg = rail_en_mask | stuck;
         tick();
         n++;
         cnt++;
         if ((rail_en_mask & ~prev) != 4'h0) mono_ok = 1'b0;
         if (down_done || rail_en_mask != prev) begin
            step_len[steps_seen] = cnt;
            steps_seen++;
            cnt  = 0;
            prev = rail_en_mask;
         end
      end
      chk("drain_steps", steps_seen, 4);
      chk("drain_mono", mono_ok, 1'b1);
      chk("drain_end_state", state_dbg, 2'd0);
      chk("drain_end_mask", rail_en_mask, 4'h0);
   endtask

   initial begin
      int edges;
      bit stayed_off;

      // Reset release with power requested, then ON, then a clean drain where PG tracks the mask.
      for (int i = 0; i < 5; i++) vecs[i] = v(1, 0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 2'd0);
      vecs[5]  = v(1, 0, 4'h0, 4'hF, 0, 0, 0, 2'd0, 2'd1);
      vecs[6]  = v(1, 0, 4'hF, 4'hF, 0, 0, 0, 2'd0, 2'd1);
      vecs[7]  = v(1, 0, 4'hF, 4'hF, 0, 0, 0, 2'd0, 2'd1);
      vecs[8]  = v(0, 0, 4'hF, 4'h7, 1, 0, 0, 2'd0, 2'd2);
      vecs[9]  = v(0, 0, 4'h7, 4'h7, 1, 0, 0, 2'd0, 2'd2);
      vecs[10] = v(0, 0, 4'h7, 4'h7, 1, 0, 0, 2'd0, 2'd2);
      vecs[11] = v(0, 0, 4'h7, 4'h3, 1, 0, 0, 2'd0, 2'd2);
      vecs[12] = v(0, 0, 4'h3, 4'h3, 1, 0, 0, 2'd0, 2'd2);
      vecs[13] = v(0, 0, 4'h3, 4'h3, 1, 0, 0, 2'd0, 2'd2);
      vecs[14] = v(0, 0, 4'h3, 4'h1, 1, 0, 0, 2'd0, 2'd2);
      vecs[15] = v(0, 0, 4'h1, 4'h1, 1, 0, 0, 2'd0, 2'd2);
      vecs[16] = v(0, 0, 4'h1, 4'h1, 1, 0, 0, 2'd0, 2'd2);
      vecs[17] = v(0, 0, 4'h1, 4'h0, 1, 0, 0, 2'd0, 2'd2);
      vecs[18] = v(0, 0, 4'h0, 4'h0, 1, 0, 0, 2'd0, 2'd2);
      vecs[19] = v(0, 0, 4'h0, 4'h0, 1, 0, 0, 2'd0, 2'd2);
      vecs[20] = v(0, 0, 4'h0, 4'h0, 0, 1, 0, 2'd0, 2'd0);
      vecs[21] = v(0, 0, 4'h0, 4'h0, 0, 0, 0, 2'd0, 2'd0);

      rst_n      = 1'b0;
      pwr_on_req = 1'b1;
      fault_in   = 1'b0;
      rail_pg    = 4'h0;
      #3;
      chk("reset_outs", outs(), 11'h0);
      @(posedge clk);
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         pwr_on_req = vecs[i].pon;
         fault_in   = vecs[i].flt;
         rail_pg    = vecs[i].pg;
         tick();
         chk($sformatf("vec%0d", i), outs(),
             {vecs[i].mask, vecs[i].busy, vecs[i].done, vecs[i].terr, vecs[i].trail, vecs[i].st});
      end

      // Rail 2 PG stuck high: its step is forced after TIMEOUT+1 cycles.
      wait_on(edges);
      chk("b_on", state_dbg, 2'd1);
      run_drain(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("b_len3", step_len[0], 3);
      chk("b_len2", step_len[1], 11);
      chk("b_len1", step_len[2], 3);
      chk("b_len0", step_len[3], 3);
      chk("b_terr", timeout_err, 1'b1);
      chk("b_trail", timeout_rail, 2'd2);
      wait_on(edges);
      chk("b_hold_edges", edges, 6);
      chk("b_on_mask", rail_en_mask, 4'hF);
      chk("b_err_clr", {timeout_err, timeout_rail}, 3'b000);

      // Fault while power is requested; fault held in OFF blocks power-on.
      run_drain(4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("c_len_sum", step_len[0] + step_len[1] + step_len[2] + step_len[3], 12);
      chk("c_terr", timeout_err, 1'b0);
      stayed_off = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (state_dbg != 2'd0 || rail_en_mask != 4'h0) stayed_off = 1'b0;
      end
      chk("c_fault_blocks", stayed_off, 1'b1);
      fault_in = 1'b0;
      tick();
      chk("c_on_after_fault", {state_dbg, rail_en_mask}, {2'd1, 4'hF});

      // Power re-requested mid-drain: drain still completes, ON only after the hold.
      run_drain(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("d_len3", step_len[0], 3);
      chk("d_len0", step_len[3], 3);
      wait_on(edges);
      chk("d_hold_edges", edges, 6);

      // Reset asserted mid-drain while rail 1 is being dropped.
      rail_pg    = 4'hF;
      pwr_on_req = 1'b0;
      tick();
      edges = 0;
      while (rail_en_mask != 4'h1 && edges < 50) begin
         rail_pg = rail_en_mask;
         tick();
         edges++;
      end
      chk("e_at_idx1", {state_dbg, rail_en_mask}, {2'd2, 4'h1});
      #2;
      rst_n = 1'b0;
      #1;
      chk("e_async_rst", {rail_en_mask, seq_busy, state_dbg}, 7'h0);
      tick();
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
